// File: rtl/scan_display_n.sv
// Time-multiplexed 7-segment scanner for NDIG digits with dead-time between slots,
// per-digit blank/blink/dp control, leading-zero suppression and a built-in hex decoder.
module scan_display_n #(
    parameter int NDIG         = 8,
    parameter int DIV          = 1,
    parameter int BLANK_CYC    = 1,
    parameter int BLINK_FRAMES = 64,
    parameter int SEG_ACT_LOW  = 0,
    parameter int SEL_ACT_LOW  = 0
) (
    input  logic                CP,
    input  logic                CR,
    input  logic [4*NDIG-1:0]   data,
    input  logic [NDIG-1:0]     dp_en,
    input  logic [NDIG-1:0]     blank,
    input  logic [NDIG-1:0]     blink,
    input  logic                lz_en,
    output logic [7:0]          codeout,
    output logic [NDIG-1:0]     seg,
    output logic                frame
);

    localparam int IW = (NDIG > 1)         ? $clog2(NDIG)         : 1;
    localparam int PW = (DIV > 1)          ? $clog2(DIV)          : 1;
    localparam int GW = (BLANK_CYC > 1)    ? $clog2(BLANK_CYC)    : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IW-1:0] IMAX = IW'(NDIG - 1);
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
    localparam logic [GW-1:0] GMAX = (BLANK_CYC > 0) ? GW'(BLANK_CYC - 1) : '0;
    localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

    localparam logic [NDIG-1:0] SEL_OFF = (SEL_ACT_LOW != 0) ? '1 : '0;
    localparam logic [7:0]      SEG_OFF = (SEG_ACT_LOW != 0) ? '1 : '0;

    typedef enum logic {SHOW, GAP} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [PW-1:0]   pcnt;
    logic [GW-1:0]   gcnt;
    logic [FW-1:0]   fcnt;
    logic            phase;

    logic            advance;
    logic            wrap;
    logic [IW-1:0]   nidx;
    logic [NDIG-1:0] zero_up;
    logic            run;
    logic [3:0]      digit;
    logic            supp;
    logic            dark;
    logic [7:0]      pattern;
    logic [NDIG-1:0] sel;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        advance = 1'b0;
        if (state == SHOW)
            advance = (pcnt == PMAX) && (BLANK_CYC == 0);
        else
            advance = (gcnt == GMAX);
        wrap = advance && (idx == IMAX);
        nidx = (idx == IMAX) ? '0 : idx + 1'b1;
    end

    // zero_up[i] = every digit from NDIG-1 down to i is zero
    always_comb begin
        zero_up = '0;
        run     = 1'b1;
        for (int unsigned k = 0; k < NDIG; k++) begin
            run = run & (data[4*(NDIG-1-k) +: 4] == 4'd0);
            zero_up[NDIG-1-k] = run;
        end
    end

    always_comb begin
        digit   = data[4*idx +: 4];
        supp    = lz_en && (idx != '0) && zero_up[idx];
        dark    = blank[idx] | (blink[idx] & phase);
        pattern = '0;
        if (!dark)
            pattern = {dp_en[idx], supp ? 7'h00 : hex7(digit)};
        sel = NDIG'(1) << idx;
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state   <= SHOW;
            idx     <= '0;
            pcnt    <= '0;
            gcnt    <= '0;
            fcnt    <= '0;
            phase   <= 1'b0;
            seg     <= SEL_OFF;
            codeout <= SEG_OFF;
            frame   <= 1'b0;
        end else begin
            frame <= wrap;
            if (state == SHOW) begin
                seg     <= sel ^ SEL_OFF;
                codeout <= pattern ^ SEG_OFF;
            end else begin
                seg     <= SEL_OFF;
                codeout <= SEG_OFF;
            end

            case (state)
                SHOW: begin
                    if (pcnt == PMAX) begin
                        pcnt <= '0;
                        if (BLANK_CYC == 0) begin
                            idx <= nidx;
                        end else begin
                            state <= GAP;
                            gcnt  <= '0;
                        end
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gcnt == GMAX) begin
                        state <= SHOW;
                        idx   <= nidx;
                        pcnt  <= '0;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: state <= SHOW;
            endcase

            if (wrap) begin
                if (fcnt == FMAX) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_display_n.sv
// Randomized bench for scan_display_n: three parameterizations share inputs and are
// compared each cycle against a slot-arithmetic reference model.
module tb_scan_display_n;

    logic        cp;
    logic        cr;
    logic [31:0] data;
    logic [7:0]  dp_en;
    logic [7:0]  blank;
    logic [7:0]  blink;
    logic        lz_en;

    logic [7:0] code_a, seg_a, code_b, seg_b, code_c, seg_c;
    logic       frame_a, frame_b, frame_c;

    int unsigned n;
    int unsigned n_checks;
    int unsigned n_fail;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    scan_display_n #(.NDIG(8), .DIV(1), .BLANK_CYC(0), .BLINK_FRAMES(2),
                     .SEG_ACT_LOW(0), .SEL_ACT_LOW(0)) dut_a (
        .CP(cp), .CR(cr), .data(data), .dp_en(dp_en), .blank(blank), .blink(blink),
        .lz_en(lz_en), .codeout(code_a), .seg(seg_a), .frame(frame_a));

    scan_display_n #(.NDIG(8), .DIV(3), .BLANK_CYC(2), .BLINK_FRAMES(2),
                     .SEG_ACT_LOW(0), .SEL_ACT_LOW(0)) dut_b (
        .CP(cp), .CR(cr), .data(data), .dp_en(dp_en), .blank(blank), .blink(blink),
        .lz_en(lz_en), .codeout(code_b), .seg(seg_b), .frame(frame_b));

    scan_display_n #(.NDIG(8), .DIV(2), .BLANK_CYC(1), .BLINK_FRAMES(1),
                     .SEG_ACT_LOW(1), .SEL_ACT_LOW(1)) dut_c (
        .CP(cp), .CR(cr), .data(data), .dp_en(dp_en), .blank(blank), .blink(blink),
        .lz_en(lz_en), .codeout(code_c), .seg(seg_c), .frame(frame_c));

    initial cp = 1'b0;
    always #5 cp = ~cp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, n, obs, exp);
        end
    endtask

    // Output after the n-th edge since reset release shows slot time n-1.
    function automatic void model(input int unsigned div, input int unsigned bc,
                                  input int unsigned bf, input bit inv,
                                  output logic [7:0] es, output logic [7:0] ec,
                                  output logic ef);
        int unsigned p, l, s, pos, d;
        bit          ph, supp, dark;
        logic [31:0] up;
        logic [3:0]  v;
        es = 8'h00;
        ec = 8'h00;
        ef = 1'b0;
        if (n != 0) begin
            p   = div + bc;
            l   = 8 * p;
            s   = n - 1;
            pos = s % l;
            d   = pos / p;
            ph  = (((s / l) / bf) % 2) == 1;
            ef  = (n % l) == 0;
            if ((pos % p) < div) begin
                es   = 8'(1 << d);
                up   = data >> (4 * d);
                supp = lz_en && (d > 0) && (up == 0);
                dark = blank[d] || (blink[d] && ph);
                v    = data[4*d +: 4];
                if (!dark)
                    ec = {dp_en[d], supp ? 7'h00 : hex_tab[v]};
            end
        end
        if (inv) begin
            es = ~es;
            ec = ~ec;
        end
    endfunction

    task automatic check_all();
        logic [7:0] es, ec;
        logic       ef;
        model(1, 0, 2, 1'b0, es, ec, ef);
        check("a.seg", 32'(seg_a), 32'(es));
        check("a.codeout", 32'(code_a), 32'(ec));
        check("a.frame", 32'(frame_a), 32'(ef));
        model(3, 2, 2, 1'b0, es, ec, ef);
        check("b.seg", 32'(seg_b), 32'(es));
        check("b.codeout", 32'(code_b), 32'(ec));
        check("b.frame", 32'(frame_b), 32'(ef));
        model(2, 1, 1, 1'b1, es, ec, ef);
        check("c.seg", 32'(seg_c), 32'(es));
        check("c.codeout", 32'(code_c), 32'(ec));
        check("c.frame", 32'(frame_c), 32'(ef));
    endtask

    task automatic step();
        @(posedge cp);
        if (!cr) n++;
        #1;
        check_all();
    endtask

    // Assert reset between edges, check the asynchronous effect, hold over an edge, release.
    task automatic reset_pulse();
        @(posedge cp);
        #3 cr = 1'b1;
        n = 0;
        #1 check_all();
        step();
        #2 cr = 1'b0;
    endtask

    task automatic randomize_inputs();
        data  = 32'($urandom) >> (4 * $urandom_range(0, 8));
        dp_en = 8'($urandom);
        blank = 8'($urandom & $urandom & $urandom);
        blink = 8'($urandom & $urandom);
        lz_en = 1'($urandom);
    endtask

    initial begin
        n        = 0;
        n_checks = 0;
        n_fail   = 0;
        cr       = 1'b1;
        data     = 32'h7654_3210;
        dp_en    = '0;
        blank    = '0;
        blink    = '0;
        lz_en    = 1'b0;
        #1 check_all();
        step();
        #2 cr = 1'b0;

        repeat (90) step();

        data  = 32'h0000_0305;
        lz_en = 1'b1;
        repeat (90) step();
        data = 32'h0;
        repeat (90) step();

        data  = 32'h89AB_CDEF;
        lz_en = 1'b0;
        blink = 8'h01;
        blank = 8'h02;
        dp_en = 8'h06;
        repeat (340) step();

        // Reset a few edges in so the scan is mid-frame when it is cut short.
        reset_pulse();
        repeat (4) step();
        reset_pulse();
        repeat (7) step();
        reset_pulse();

        repeat (2500) begin
            step();
            if ($urandom_range(0, 7) == 0) randomize_inputs();
            if ($urandom_range(0, 399) == 0) reset_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
